// File: rtl/serial_loader_pkg.sv
// Shared constants, FSM state encoding and helpers for the serial memory loader.
package loader_pkg;

    localparam logic [7:0] SYNC_LOAD = 8'h55;
    localparam logic [7:0] SYNC_GO   = 8'hAA;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_RESP,
        ST_GO_HI,
        ST_GO_LO
    } state_t;

    // A length byte of zero encodes a full 256-byte payload.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/serial_loader_if.sv
// Serial stream, response, memory-bus and control signals of the serial loader.
interface serial_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        hold_req;
    logic        hold_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        go;
    logic [15:0] go_addr;
    logic        busy;
    logic        err;

    modport master (
        input  rx_valid, rx_data, tx_ready, hold_ack,
        output tx_valid, tx_data, hold_req, mem_addr, mem_wdata, mem_we,
               go, go_addr, busy, err
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, hold_ack,
        input  tx_valid, tx_data, hold_req, mem_addr, mem_wdata, mem_we,
               go, go_addr, busy, err
    );

endinterface

// File: rtl/serial_loader_byte_timer.sv
// Inter-byte idle counter: expired is high during the CYCLES-th consecutive idle cycle.
module byte_timer #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

    // count holds the idle cycles already completed, so the current cycle is number count+1
    assign expired = enable && !clear && (count == W'(CYCLES - 1));

endmodule

// File: rtl/serial_loader.sv
// Serial frame loader: parses load/go frames from the receive stream, takes the
// memory bus via hold/ack, writes the payload and answers ACK/NAK.
module serial_loader
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset_n,
    serial_loader_if.master bus
);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        hold_req_q, hold_req_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        go_q, go_d;
    logic [15:0] go_addr_q, go_addr_d;
    logic [7:0]  go_hi_q, go_hi_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [7:0]  csum_q, csum_d;
    logic [8:0]  count_q, count_d;
    logic [8:0]  len_q, len_d;
    logic        overrun_q, overrun_d;

    logic        timer_en;
    logic        timed_out;
    logic [7:0]  sum_next;
    logic        nak;

    assign timer_en = (state_q != ST_IDLE) && (state_q != ST_RESP);

    byte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bus.rx_valid),
        .enable  (timer_en),
        .expired (timed_out)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        hold_req_d = hold_req_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        go_d       = 1'b0;
        go_addr_d  = go_addr_q;
        go_hi_d    = go_hi_q;
        busy_d     = busy_q;
        err_d      = err_q;
        csum_d     = csum_q;
        count_d    = count_q;
        len_d      = len_q;
        overrun_d  = overrun_q;
        sum_next   = csum_q + bus.rx_data;
        nak        = (sum_next != 8'h00) || overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_LOAD) begin
                    state_d    = ST_ADDR_HI;
                    hold_req_d = 1'b1;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    csum_d     = '0;
                    count_d    = '0;
                    overrun_d  = 1'b0;
                end else if (bus.rx_valid && bus.rx_data == SYNC_GO) begin
                    state_d = ST_GO_HI;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_ADDR_HI: if (bus.rx_valid) begin
                addr_d  = {bus.rx_data, addr_q[7:0]};
                csum_d  = sum_next;
                state_d = ST_ADDR_LO;
            end
            ST_ADDR_LO: if (bus.rx_valid) begin
                addr_d  = {addr_q[15:8], bus.rx_data};
                csum_d  = sum_next;
                state_d = ST_LEN;
            end
            ST_LEN: if (bus.rx_valid) begin
                len_d   = frame_len(bus.rx_data);
                csum_d  = sum_next;
                state_d = ST_DATA;
            end
            ST_DATA: if (bus.rx_valid) begin
                wdata_d = bus.rx_data;
                csum_d  = sum_next;
                count_d = count_q + 9'd1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.rx_valid) begin
                    overrun_d = 1'b1;
                end
                // Leave WRITE as the strobe is issued; the address advances after the strobe cycle.
                if (bus.hold_ack) begin
                    we_d    = 1'b1;
                    state_d = (count_q == len_q) ? ST_CSUM : ST_DATA;
                end
            end
            ST_CSUM: if (bus.rx_valid) begin
                tx_data_d  = nak ? RESP_NAK : RESP_ACK;
                tx_valid_d = 1'b1;
                hold_req_d = 1'b0;
                err_d      = nak;
                state_d    = ST_RESP;
            end
            ST_RESP: if (tx_valid_q && bus.tx_ready) begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_GO_HI: if (bus.rx_valid) begin
                go_hi_d = bus.rx_data;
                state_d = ST_GO_LO;
            end
            ST_GO_LO: if (bus.rx_valid) begin
                go_addr_d = {go_hi_q, bus.rx_data};
                go_d      = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (we_q) begin
            addr_d = addr_q + 16'd1;
        end

        if (timed_out) begin
            err_d = 1'b1;
            if (state_q == ST_GO_HI || state_q == ST_GO_LO) begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end else begin
                we_d       = 1'b0;
                hold_req_d = 1'b0;
                tx_data_d  = RESP_NAK;
                tx_valid_d = 1'b1;
                state_d    = ST_RESP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            hold_req_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            go_q       <= 1'b0;
            go_addr_q  <= '0;
            go_hi_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            csum_q     <= '0;
            count_q    <= '0;
            len_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            hold_req_q <= hold_req_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            go_q       <= go_d;
            go_addr_q  <= go_addr_d;
            go_hi_q    <= go_hi_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            csum_q     <= csum_d;
            count_q    <= count_d;
            len_q      <= len_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.hold_req  = hold_req_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.go        = go_q;
    assign bus.go_addr   = go_addr_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: directed frames plus randomized load frames
// compared against a frame-level reference model (expected writes and response byte).
module tb_serial_loader;
    import loader_pkg::*;

    localparam int unsigned TO = 50;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    serial_loader_if bus ();

    serial_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Observations collected by the monitor; tests compare against snapshots taken before each frame.
    int unsigned cyc = 0;
    logic [23:0] we_q[$];
    logic [7:0]  tx_q[$];
    int unsigned tx_rise_q[$];
    int unsigned go_cnt = 0;
    logic [15:0] go_seen_addr = '0;
    int unsigned go_cyc = 0;
    int unsigned hreq_cycles = 0;
    int unsigned viol = 0;
    int unsigned strobe_cyc = 0;

    bit          ack_tied = 1'b1;
    int unsigned ack_delay = 0;
    bit          ready_rand = 1'b0;
    int unsigned hreq_age = 0;

    logic [7:0] payload[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CPU and transmitter models, driven just after the active edge.
    initial begin
        bus.hold_ack = 1'b0;
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!bus.hold_req) hreq_age = 0;
            else if (hreq_age < 1000) hreq_age++;
            bus.hold_ack = ack_tied ? 1'b1 : (bus.hold_req && hreq_age > ack_delay);
            bus.tx_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : monitor
        logic ack_prev, we_prev, txv_prev, hs_prev;
        logic [7:0] txd_prev;
        ack_prev = 1'b0; we_prev = 1'b0; txv_prev = 1'b0; hs_prev = 1'b0; txd_prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if (bus.mem_we) begin
                    we_q.push_back({bus.mem_addr, bus.mem_wdata});
                    if (!ack_prev || !bus.hold_req || we_prev) viol++;
                end
                if (bus.tx_valid && !txv_prev) tx_rise_q.push_back(cyc);
                if (bus.tx_valid && txv_prev && !hs_prev && bus.tx_data != txd_prev) viol++;
                if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
                if (bus.go) begin
                    go_cnt++;
                    go_seen_addr = bus.go_addr;
                    go_cyc = cyc;
                end
                if (bus.hold_req) hreq_cycles++;
            end
            ack_prev = bus.hold_ack;
            we_prev  = bus.mem_we;
            txv_prev = bus.tx_valid;
            hs_prev  = bus.tx_valid && bus.tx_ready;
            txd_prev = bus.tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        @(posedge clk);
        #2;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        strobe_cyc   = cyc + 1;
        @(posedge clk);
        #2;
        bus.rx_valid = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " ctl"},  {26'd0, bus.hold_req, bus.mem_we, bus.tx_valid, bus.go, bus.busy, bus.err}, 32'd0);
        check({tag, " addr"}, {bus.mem_addr, bus.go_addr}, 32'd0);
        check({tag, " data"}, {16'd0, bus.mem_wdata, bus.tx_data}, 32'd0);
    endtask

    task automatic wait_tx(input int unsigned tx0, input int unsigned budget, input string tag);
        int unsigned k;
        k = 0;
        while (tx_q.size() <= tx0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({tag, " resp_seen"}, 32'(tx_q.size() > tx0), 32'd1);
    endtask

    // Sends an optional run of junk bytes and then one load frame built from payload.
    task automatic run_load(input logic [15:0] base, input logic [7:0] cs_flip, input int unsigned gap,
                            input int unsigned n_junk, input bit exp_overrun, input string tag);
        logic [7:0] len_b, sum, cs, resp, junk;
        int unsigned we0, tx0, rise0, v0, cs_cyc;
        we0 = we_q.size(); tx0 = tx_q.size(); rise0 = tx_rise_q.size(); v0 = viol;
        for (int i = 0; i < int'(n_junk); i++) begin
            junk = 8'($urandom);
            if (junk == SYNC_LOAD || junk == SYNC_GO) junk = junk ^ 8'h01;
            send_byte(junk, 3);
        end
        len_b = 8'(payload.size());
        sum = base[15:8] + base[7:0] + len_b;
        foreach (payload[i]) sum = sum + payload[i];
        cs = (8'h00 - sum) ^ cs_flip;
        resp = (8'(sum + cs) == 8'h00 && !exp_overrun) ? RESP_ACK : RESP_NAK;

        send_byte(SYNC_LOAD, gap);
        send_byte(base[15:8], gap);
        send_byte(base[7:0], gap);
        send_byte(len_b, gap);
        foreach (payload[i]) send_byte(payload[i], gap);
        send_byte(cs, gap);
        cs_cyc = strobe_cyc;
        wait_tx(tx0, 400, tag);
        repeat (4) @(posedge clk);
        @(negedge clk);

        if (!exp_overrun) begin
            check({tag, " n_writes"}, 32'(we_q.size() - we0), 32'(payload.size()));
            for (int i = 0; i < payload.size() && we0 + i < we_q.size(); i++)
                check({tag, " write"}, 32'(we_q[we0 + i]), {8'd0, base + 16'(i), payload[i]});
            check({tag, " tx_latency"}, (tx_rise_q.size() > rise0) ? tx_rise_q[rise0] : 32'd0, cs_cyc + 1);
        end
        check({tag, " n_resp"}, 32'(tx_q.size() - tx0), 32'd1);
        check({tag, " resp"}, (tx_q.size() > tx0) ? 32'(tx_q[tx0]) : 32'hFFFF, 32'(resp));
        check({tag, " err"}, 32'(bus.err), 32'(resp == RESP_NAK));
        check({tag, " idle"}, {29'd0, bus.hold_req, bus.busy, bus.tx_valid}, 32'd0);
        check({tag, " protocol"}, viol - v0, 32'd0);
    endtask

    initial begin
        int unsigned tx0, we0, g0, h0, last;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;

        #3;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        payload = '{8'hC3, 8'h00};
        run_load(16'h0100, 8'h00, 2, 0, 1'b0, "load_ack");
        run_load(16'h0100, 8'h01, 2, 0, 1'b0, "load_bad_cs");

        ack_tied = 1'b0; ack_delay = 20;
        run_load(16'h0100, 8'h00, 8, 0, 1'b0, "hold_delay");
        ack_tied = 1'b1;

        g0 = go_cnt; h0 = hreq_cycles; tx0 = tx_q.size();
        send_byte(SYNC_GO, 3);
        send_byte(8'h12, 3);
        send_byte(8'h34, 3);
        last = strobe_cyc;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("go count", go_cnt - g0, 32'd1);
        check("go addr at pulse", 32'(go_seen_addr), 32'h1234);
        check("go latency", go_cyc, last + 1);
        check("go addr held", 32'(bus.go_addr), 32'h1234);
        check("go no hold_req", hreq_cycles - h0, 32'd0);
        check("go no resp", 32'(tx_q.size() - tx0), 32'd0);

        payload = '{8'h11, 8'h22};
        run_load(16'hFFFF, 8'h00, 3, 0, 1'b0, "addr_wrap");

        g0 = go_cnt; tx0 = tx_q.size();
        send_byte(SYNC_GO, 3);
        send_byte(8'h56, 3);
        repeat (TO + 20) @(posedge clk);
        @(negedge clk);
        check("go_to no pulse", go_cnt - g0, 32'd0);
        check("go_to err", 32'(bus.err), 32'd1);
        check("go_to busy", 32'(bus.busy), 32'd0);
        check("go_to no resp", 32'(tx_q.size() - tx0), 32'd0);
        check("go_to addr kept", 32'(bus.go_addr), 32'h1234);

        tx0 = tx_q.size(); we0 = we_q.size(); h0 = hreq_cycles;
        send_byte(SYNC_LOAD, 3);
        send_byte(8'h01, 3);
        send_byte(8'h00, 3);
        last = strobe_cyc;
        wait_tx(tx0, 200, "load_to");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("load_to latency", (tx_rise_q.size() > 0) ? tx_rise_q[tx_rise_q.size() - 1] : 32'd0, last + TO + 1);
        check("load_to resp", (tx_q.size() > tx0) ? 32'(tx_q[tx0]) : 32'hFFFF, 32'(RESP_NAK));
        check("load_to err", 32'(bus.err), 32'd1);
        check("load_to hold_req seen", 32'(hreq_cycles > h0), 32'd1);
        check("load_to idle", {30'd0, bus.hold_req, bus.busy}, 32'd0);
        check("load_to no writes", 32'(we_q.size() - we0), 32'd0);

        ack_tied = 1'b0; ack_delay = 40;
        payload = '{8'hA1, 8'hA2};
        run_load(16'h3000, 8'h00, 3, 0, 1'b1, "overrun");
        ack_tied = 1'b1;

        ready_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            logic [7:0] flip;
            int unsigned n;
            payload.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < int'(n); i++) payload.push_back(8'($urandom));
            flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            ack_tied = 1'($urandom_range(0, 1));
            ack_delay = $urandom_range(0, 25);
            run_load(16'($urandom), flip, ack_tied ? $urandom_range(2, 4) : 8,
                     $urandom_range(0, 2), 1'b0, "random");
        end
        ack_tied = 1'b1;

        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'($urandom));
        run_load(16'($urandom), 8'h00, 2, 0, 1'b0, "len256");
        ready_rand = 1'b0;

        tx0 = tx_q.size(); we0 = we_q.size();
        send_byte(SYNC_LOAD, 3);
        send_byte(8'h20, 3);
        send_byte(8'h00, 3);
        send_byte(8'h04, 3);
        send_byte(8'h11, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid hold_req", 32'(bus.hold_req), 32'd1);
        check("mid busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("mid no resp", 32'(tx_q.size() - tx0), 32'd0);
        check("mid one write", 32'(we_q.size() - we0), 32'd1);
        check_outputs_zero("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
